calendar_set_seq: RTL and testbench
===================================

CALENDAR_SET_SEQ -- requirements
Module: calendar_set_seq

Interface
REQ-001 Parameter SETTLE_CYCLES, default 8: clk_50MHz cycles waited after each tick edge before re-sampling the current date.
REQ-002 Parameter MAX_STEPS, default 511: total increment pulses allowed per set operation before the block aborts with an error.
REQ-003 clk_50MHz  input  1  single system clock; all state updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 tick_1Hz  input  1  1 Hz tick, asynchronous to clk_50MHz; the calendar samples inc_* on its rising edge.
REQ-006 start  input  1  one-cycle request to begin a set operation; sampled only in IDLE.
REQ-007 abort  input  1  cancels an operation in progress.
REQ-008 tgt_m_10s, tgt_m_1s, tgt_d_10s, tgt_d_1s, tgt_y_10s, tgt_y_1s, tgt_c_10s, tgt_c_1s  input  4 each  target date (BCD); captured on an accepted start.
REQ-009 m_10s, m_1s, d_10s, d_1s, y_10s, y_1s, c_10s, c_1s  input  4 each  current calendar date (BCD).
REQ-010 inc_month, inc_day, inc_year, inc_century  output  1 each  registered increment requests to the calendar; at most one high at any time.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 done  output  1  one-cycle pulse when the current date equals the target.
REQ-013 err  output  1  one-cycle pulse on an invalid target, a step overflow or an abort.

Function
REQ-014 tick_1Hz SHALL pass through a 2-FF synchronizer; tick_rise = sync1 & ~sync2.
REQ-015 BCD inputs SHALL be converted to binary (10*tens + ones), 7-bit each.
REQ-016 States SHALL be IDLE, VALIDATE, SELECT, PULSE, SETTLE, DONE, ERR.
REQ-017 IDLE: start=1 -> capture the target, clear the 10-bit step counter, go to VALIDATE; start while busy is ignored.
REQ-018 VALIDATE (1 cycle): any target digit >9, month not in 1..12, or day not in 1..dim(month) -> ERR; otherwise -> SELECT.
REQ-019 dim() SHALL be 31 for months 1,3,5,7,8,10,12; 30 for months 4,6,9,11; for February, 29 when target year%4==0, else 28.
REQ-020 SELECT (1 cycle) SHALL compare fields in the fixed order century, year, month, day; the first mismatching field is chosen and the block goes to PULSE; if all fields match -> DONE.
REQ-021 SELECT with step counter == MAX_STEPS and a mismatch -> ERR.
REQ-022 PULSE: assert only the chosen inc_* and hold it until tick_rise; on tick_rise deassert it (next cycle), increment the step counter, and go to SETTLE.
REQ-023 SETTLE: count SETTLE_CYCLES cycles with all inc_* low, then go to SELECT.
REQ-024 Increments of the current date caused by end of day SHALL need no special handling; SELECT re-evaluates from the live inputs.
REQ-025 Wrap-around (99->0 for year or century, 12->1 for month, day rollover) SHALL be reached by continued pulsing; the block never decrements.
REQ-026 DONE: done=1 for one cycle -> IDLE. ERR: err=1 for one cycle -> IDLE.
REQ-027 abort=1 in any state except IDLE SHALL force all inc_* low next cycle and go to ERR; abort takes priority over tick_rise.
REQ-028 Latency: a matching target gives done 3 cycles after start (VALIDATE, SELECT, DONE).

Reset
REQ-029 reset=1 SHALL force IDLE next cycle, with inc_*=0, busy=0, done=0, err=0, step counter=0 and synchronizer flops=0, including mid-PULSE.
REQ-030 No output SHALL depend on power-up values; only reset defines state.

Verification
REQ-031 Current date 03/23/24/20, target 03/23/24/20, start -> done pulse 3 cycles after start, no inc_* asserted.
REQ-032 Current 03/23/24/20, target 05/23/24/20 -> exactly two inc_month pulses, each spanning one tick_rise; then done; busy high throughout.
REQ-033 Target 02/29/23/20 -> err pulse after VALIDATE, no inc_*; target 02/29/24/20 is accepted.
REQ-034 Current year 98, target year 01 (other fields equal) -> 3 inc_year pulses (98->99->00->01), then done.
REQ-035 abort asserted mid-PULSE -> inc_* low next cycle, err pulse, IDLE; reset asserted mid-SETTLE -> all outputs 0 next cycle.
REQ-036 Calendar model frozen (never increments) with MAX_STEPS=4 -> err after the 4th pulse; start pulsed while busy has no effect.

Source files
------------

// File: rtl/calendar_set_seq_if.sv
// Handshake and date bus between the set sequencer and its calendar/controller.
// The master side drives the requests and the live calendar date; the slave side is the sequencer.
interface calendar_set_seq_if;
  logic       tick_1Hz;
  logic       start;
  logic       abort;
  logic [3:0] tgt_m_10s, tgt_m_1s, tgt_d_10s, tgt_d_1s;
  logic [3:0] tgt_y_10s, tgt_y_1s, tgt_c_10s, tgt_c_1s;
  logic [3:0] m_10s, m_1s, d_10s, d_1s;
  logic [3:0] y_10s, y_1s, c_10s, c_1s;
  logic       inc_month, inc_day, inc_year, inc_century;
  logic       busy, done, err;

  modport master (
    output tick_1Hz, start, abort,
    output tgt_m_10s, tgt_m_1s, tgt_d_10s, tgt_d_1s,
    output tgt_y_10s, tgt_y_1s, tgt_c_10s, tgt_c_1s,
    output m_10s, m_1s, d_10s, d_1s, y_10s, y_1s, c_10s, c_1s,
    input  inc_month, inc_day, inc_year, inc_century,
    input  busy, done, err
  );

  modport slave (
    input  tick_1Hz, start, abort,
    input  tgt_m_10s, tgt_m_1s, tgt_d_10s, tgt_d_1s,
    input  tgt_y_10s, tgt_y_1s, tgt_c_10s, tgt_c_1s,
    input  m_10s, m_1s, d_10s, d_1s, y_10s, y_1s, c_10s, c_1s,
    output inc_month, inc_day, inc_year, inc_century,
    output busy, done, err
  );
endinterface

// File: rtl/calendar_set_seq.sv
// Walks a BCD calendar forward to a target date by issuing one increment request per 1 Hz tick,
// re-reading the live date after each settle period. Never decrements; wrap is reached by pulsing.
module calendar_set_seq #(
  parameter int unsigned SETTLE_CYCLES = 8,
  parameter int unsigned MAX_STEPS     = 511
) (
  input logic               clk_50MHz,
  input logic               reset,
  calendar_set_seq_if.slave bus
);

  typedef enum logic [2:0] {
    StIdle, StValidate, StSelect, StPulse, StSettle, StDone, StErr
  } state_e;

  state_e      state_q;
  logic        sync1_q, sync2_q;
  logic        tick_rise;
  logic [31:0] tgt_q;     // {m10, m1, d10, d1, y10, y1, c10, c1}
  logic [9:0]  step_q;
  logic [15:0] settle_q;
  logic [3:0]  inc_q;     // {century, year, month, day}
  logic        busy_q, done_q, err_q;

  logic [6:0]  t_mon, t_day, t_year, t_cent;
  logic [6:0]  c_mon, c_day, c_year, c_cent;
  logic [6:0]  t_dim;
  logic        digit_bad;
  logic        tgt_valid;
  logic [3:0]  sel;

  function automatic logic [6:0] bcd2bin(input logic [3:0] tens, input logic [3:0] ones);
    return 7'({3'b000, tens} * 7'd10) + {3'b000, ones};
  endfunction

  function automatic logic [6:0] days_in_month(input logic [6:0] mon, input logic leap);
    logic [6:0] dim;
    case (mon)
      7'd4, 7'd6, 7'd9, 7'd11: dim = 7'd30;
      7'd2:                    dim = leap ? 7'd29 : 7'd28;
      default:                 dim = 7'd31;
    endcase
    return dim;
  endfunction

  assign tick_rise = sync1_q & ~sync2_q;

  assign t_mon  = bcd2bin(tgt_q[31:28], tgt_q[27:24]);
  assign t_day  = bcd2bin(tgt_q[23:20], tgt_q[19:16]);
  assign t_year = bcd2bin(tgt_q[15:12], tgt_q[11:8]);
  assign t_cent = bcd2bin(tgt_q[7:4],   tgt_q[3:0]);

  assign c_mon  = bcd2bin(bus.m_10s, bus.m_1s);
  assign c_day  = bcd2bin(bus.d_10s, bus.d_1s);
  assign c_year = bcd2bin(bus.y_10s, bus.y_1s);
  assign c_cent = bcd2bin(bus.c_10s, bus.c_1s);

  // Leap rule looks only at the two-digit year of the target.
  assign t_dim = days_in_month(t_mon, t_year[1:0] == 2'b00);

  always_comb begin
    digit_bad = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (tgt_q[4*i +: 4] > 4'd9) digit_bad = 1'b1;
    end
  end

  assign tgt_valid = !digit_bad && (t_mon >= 7'd1) && (t_mon <= 7'd12) &&
                     (t_day >= 7'd1) && (t_day <= t_dim);

  // First mismatching field in century, year, month, day order.
  always_comb begin
    sel = 4'b0000;
    if (c_cent != t_cent)      sel = 4'b1000;
    else if (c_year != t_year) sel = 4'b0100;
    else if (c_mon != t_mon)   sel = 4'b0010;
    else if (c_day != t_day)   sel = 4'b0001;
  end

  always_ff @(posedge clk_50MHz) begin
    if (reset) begin
      state_q  <= StIdle;
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      tgt_q    <= '0;
      step_q   <= '0;
      settle_q <= '0;
      inc_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      sync1_q <= bus.tick_1Hz;
      sync2_q <= sync1_q;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      // ERR is excluded so an abort held high cannot stretch the err pulse.
      if (bus.abort && (state_q != StIdle) && (state_q != StErr)) begin
        inc_q   <= '0;
        err_q   <= 1'b1;
        state_q <= StErr;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (bus.start) begin
              tgt_q   <= {bus.tgt_m_10s, bus.tgt_m_1s, bus.tgt_d_10s, bus.tgt_d_1s,
                          bus.tgt_y_10s, bus.tgt_y_1s, bus.tgt_c_10s, bus.tgt_c_1s};
              step_q  <= '0;
              busy_q  <= 1'b1;
              state_q <= StValidate;
            end
          end
          StValidate: begin
            if (tgt_valid) begin
              state_q <= StSelect;
            end else begin
              err_q   <= 1'b1;
              state_q <= StErr;
            end
          end
          StSelect: begin
            if (sel == 4'b0000) begin
              done_q  <= 1'b1;
              state_q <= StDone;
            end else if (step_q == 10'(MAX_STEPS)) begin
              err_q   <= 1'b1;
              state_q <= StErr;
            end else begin
              inc_q   <= sel;
              state_q <= StPulse;
            end
          end
          StPulse: begin
            if (tick_rise) begin
              inc_q    <= '0;
              step_q   <= step_q + 10'd1;
              settle_q <= '0;
              state_q  <= StSettle;
            end
          end
          StSettle: begin
            if (settle_q == 16'(SETTLE_CYCLES - 1)) begin
              state_q <= StSelect;
            end else begin
              settle_q <= settle_q + 16'd1;
            end
          end
          StDone, StErr: begin
            busy_q  <= 1'b0;
            state_q <= StIdle;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign bus.inc_century = inc_q[3];
  assign bus.inc_year    = inc_q[2];
  assign bus.inc_month   = inc_q[1];
  assign bus.inc_day     = inc_q[0];
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.err         = err_q;

endmodule

// File: tb/tb_calendar_set_seq.sv
// Directed bench: dut0 drives a behavioural calendar, dut1 (MAX_STEPS=4) sees a frozen date.
module tb_calendar_set_seq;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic tick  = 1'b0;

  always #5 clk = ~clk;
  // Tick edges land on clk negedges, clear of the DUT's sampling edge.
  always #200 tick = ~tick;

  calendar_set_seq_if bus0 ();
  calendar_set_seq_if bus1 ();

  calendar_set_seq dut0 (
    .clk_50MHz (clk),
    .reset     (reset),
    .bus       (bus0)
  );

  calendar_set_seq #(
    .MAX_STEPS (4)
  ) dut1 (
    .clk_50MHz (clk),
    .reset     (reset),
    .bus       (bus1)
  );

  int cm, cd, cy, cc;
  int n_cmp  = 0;
  int n_fail = 0;

  assign bus0.tick_1Hz = tick;
  assign bus1.tick_1Hz = tick;
  assign bus0.m_10s = 4'(cm / 10);
  assign bus0.m_1s  = 4'(cm % 10);
  assign bus0.d_10s = 4'(cd / 10);
  assign bus0.d_1s  = 4'(cd % 10);
  assign bus0.y_10s = 4'(cy / 10);
  assign bus0.y_1s  = 4'(cy % 10);
  assign bus0.c_10s = 4'(cc / 10);
  assign bus0.c_1s  = 4'(cc % 10);
  assign {bus1.m_10s, bus1.m_1s, bus1.d_10s, bus1.d_1s} = 16'h0323;
  assign {bus1.y_10s, bus1.y_1s, bus1.c_10s, bus1.c_1s} = 16'h2420;

  function automatic int dim_f(int m, int y);
    if (m == 4 || m == 6 || m == 9 || m == 11) return 30;
    if (m == 2) return (y % 4 == 0) ? 29 : 28;
    return 31;
  endfunction

  // Calendar model: samples the increment requests on the tick rising edge.
  always @(posedge tick) begin
    if (bus0.inc_month)   cm = (cm == 12) ? 1 : cm + 1;
    if (bus0.inc_day)     cd = (cd >= dim_f(cm, cy)) ? 1 : cd + 1;
    if (bus0.inc_year)    cy = (cy + 1) % 100;
    if (bus0.inc_century) cc = (cc + 1) % 100;
  end

  typedef struct {
    string       name;
    logic [31:0] tgt;   // BCD mm dd yy cc
    int          m, d, y, c;
    int          res;   // 1 = done, 2 = err
    int          nm, nd, ny, nc;
    int          cyc;   // cycles from start to done/err, -1 = not checked
  } vec_t;

  vec_t vecs[13];

  function automatic vec_t mk(string n, logic [31:0] t, int m, int d, int y, int c, int res,
                              int nm, int nd, int ny, int nc, int cyc);
    vec_t v;
    v.name = n; v.tgt = t; v.m = m; v.d = d; v.y = y; v.c = c; v.res = res;
    v.nm = nm; v.nd = nd; v.ny = ny; v.nc = nc; v.cyc = cyc;
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic logic [3:0] inc0();
    return {bus0.inc_century, bus0.inc_year, bus0.inc_month, bus0.inc_day};
  endfunction

  task automatic set_tgt0(input logic [31:0] t);
    {bus0.tgt_m_10s, bus0.tgt_m_1s, bus0.tgt_d_10s, bus0.tgt_d_1s,
     bus0.tgt_y_10s, bus0.tgt_y_1s, bus0.tgt_c_10s, bus0.tgt_c_1s} = t;
  endtask

  task automatic set_tgt1(input logic [31:0] t);
    {bus1.tgt_m_10s, bus1.tgt_m_1s, bus1.tgt_d_10s, bus1.tgt_d_1s,
     bus1.tgt_y_10s, bus1.tgt_y_1s, bus1.tgt_c_10s, bus1.tgt_c_1s} = t;
  endtask

  task automatic run_vec(input vec_t v);
    int nm = 0, nd = 0, ny = 0, nc = 0, bad1h = 0, nobusy = 0, cyc = 0, res = 0;
    logic [3:0] prev, cur;
    prev = 4'b0000;
    cm = v.m; cd = v.d; cy = v.y; cc = v.c;
    set_tgt0(v.tgt);
    bus0.start = 1'b1;
    @(negedge clk);
    bus0.start = 1'b0;
    cyc = 1;
    for (int i = 0; i < 3000; i++) begin
      cur = inc0();
      if (!$onehot0(cur)) bad1h++;
      if (!bus0.busy) nobusy++;
      if (cur[3] & ~prev[3]) nc++;
      if (cur[2] & ~prev[2]) ny++;
      if (cur[1] & ~prev[1]) nm++;
      if (cur[0] & ~prev[0]) nd++;
      prev = cur;
      if (bus0.done || bus0.err) begin
        res = {30'd0, bus0.err, bus0.done};
        break;
      end
      @(negedge clk);
      cyc++;
    end
    chk({v.name, " outcome"}, res, v.res);
    chk({v.name, " inc_month"}, nm, v.nm);
    chk({v.name, " inc_day"}, nd, v.nd);
    chk({v.name, " inc_year"}, ny, v.ny);
    chk({v.name, " inc_century"}, nc, v.nc);
    chk({v.name, " onehot"}, bad1h, 0);
    chk({v.name, " busy"}, nobusy, 0);
    if (v.cyc >= 0) chk({v.name, " latency"}, cyc, v.cyc);
    @(negedge clk);
    chk({v.name, " idle_after"}, {28'd0, inc0(), bus0.busy, bus0.done, bus0.err}, 0);
  endtask

  // Waits for a given inc_month level; returns 0 if the bound expires.
  task automatic wait_month(input logic lvl, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (bus0.inc_month == lvl) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int n1, res1;
    logic prev1;
    cm = 3; cd = 23; cy = 24; cc = 20;
    bus0.start = 1'b0; bus0.abort = 1'b0;
    bus1.start = 1'b0; bus1.abort = 1'b0;
    set_tgt0(32'h03232420);
    set_tgt1(32'h05232420);

    vecs[0]  = mk("match",      32'h03232420,  3, 23, 24, 20, 1, 0, 0, 0, 0,  3);
    vecs[1]  = mk("month2",     32'h05232420,  3, 23, 24, 20, 1, 2, 0, 0, 0, -1);
    vecs[2]  = mk("feb29_23",   32'h02292320,  3, 23, 24, 20, 2, 0, 0, 0, 0,  2);
    vecs[3]  = mk("feb29_24",   32'h02292420,  2, 27, 24, 20, 1, 0, 2, 0, 0, -1);
    vecs[4]  = mk("year_wrap",  32'h03230120,  3, 23, 98, 20, 1, 0, 0, 3, 0, -1);
    vecs[5]  = mk("month_wrap", 32'h01312420, 12, 31, 24, 20, 1, 1, 0, 0, 0, -1);
    vecs[6]  = mk("multi",      32'h03252521,  3, 23, 24, 20, 1, 0, 2, 1, 1, -1);
    vecs[7]  = mk("day_roll",   32'h04012420,  4, 30, 24, 20, 1, 0, 1, 0, 0, -1);
    vecs[8]  = mk("month13",    32'h13012420,  3, 23, 24, 20, 2, 0, 0, 0, 0,  2);
    vecs[9]  = mk("day_zero",   32'h01002420,  3, 23, 24, 20, 2, 0, 0, 0, 0,  2);
    vecs[10] = mk("bad_digit",  32'h01012A20,  3, 23, 24, 20, 2, 0, 0, 0, 0,  2);
    vecs[11] = mk("apr31",      32'h04312420,  3, 23, 24, 20, 2, 0, 0, 0, 0,  2);
    vecs[12] = mk("feb30_24",   32'h02302420,  3, 23, 24, 20, 2, 0, 0, 0, 0,  2);

    repeat (4) @(negedge clk);
    chk("reset dut0 outs", {28'd0, inc0(), bus0.busy, bus0.done, bus0.err}, 0);
    chk("reset dut1 outs", {25'd0, bus1.inc_century, bus1.inc_year, bus1.inc_month,
                            bus1.inc_day, bus1.busy, bus1.done, bus1.err}, 0);
    reset = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Abort while an increment request is held.
    cm = 3; cd = 23; cy = 24; cc = 20;
    set_tgt0(32'h05232420);
    bus0.start = 1'b1;
    @(negedge clk);
    bus0.start = 1'b0;
    wait_month(1'b1, ok);
    chk("abort reached pulse", int'(ok), 1);
    bus0.abort = 1'b1;
    @(negedge clk);
    bus0.abort = 1'b0;
    chk("abort inc low", {28'd0, inc0()}, 0);
    chk("abort err", int'(bus0.err), 1);
    @(negedge clk);
    chk("abort idle", {29'd0, bus0.busy, bus0.done, bus0.err}, 0);

    // Reset during the settle window after the first pulse.
    cm = 3; cd = 23; cy = 24; cc = 20;
    bus0.start = 1'b1;
    @(negedge clk);
    bus0.start = 1'b0;
    wait_month(1'b1, ok);
    if (ok) wait_month(1'b0, ok);
    chk("reset reached settle", int'(ok), 1);
    reset = 1'b1;
    @(negedge clk);
    chk("reset mid-settle outs", {28'd0, inc0(), bus0.busy, bus0.done, bus0.err}, 0);
    reset = 1'b0;
    @(negedge clk);
    run_vec(vecs[1]);

    // Frozen calendar with a 4-step budget; a second start while busy must be ignored.
    n1 = 0; res1 = 0; prev1 = 1'b0;
    set_tgt1(32'h05232420);
    bus1.start = 1'b1;
    @(negedge clk);
    bus1.start = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (i == 6) begin
        set_tgt1(32'h03232420);
        bus1.start = 1'b1;
      end else begin
        bus1.start = 1'b0;
      end
      if (bus1.inc_month && !prev1) n1++;
      prev1 = bus1.inc_month;
      if (bus1.done || bus1.err) begin
        res1 = {30'd0, bus1.err, bus1.done};
        break;
      end
      @(negedge clk);
    end
    bus1.start = 1'b0;
    chk("max_steps pulses", n1, 4);
    chk("max_steps outcome", res1, 2);
    @(negedge clk);
    chk("max_steps idle", {29'd0, bus1.busy, bus1.done, bus1.err}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
